// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: redirect input, instruction-memory request/response and decode handshake.
// master = fetch_queue side, slave = pipeline/memory side.
interface fetch_queue_if #(
    parameter int WIDTH = 32
);
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_resp_valid;
    logic [WIDTH-1:0] imem_resp_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_instr;
    logic [WIDTH-1:0] out_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
               imem_resp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
               imem_resp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues in-order imem requests, buffers {instr, pc}.
// Optional macro FETCHQ_BYPASS_EN forwards a response filling an empty head straight to decode.
module fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [WIDTH-1:0] fetch_pc;
    logic [PTR_W-1:0] alloc_ptr, fill_ptr, head_ptr;
    logic [CNT_W-1:0] alloc_cnt, pend_cnt, drop_cnt;
    logic [DEPTH-1:0] filled, filled_nxt;
    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic             active;

    logic             issue, fill, resp_drop, head_filled, bypass, pop;
    logic [CNT_W:0]   inflight;
    logic [CNT_W-1:0] drop_sum, drop_redir;
    logic [WIDTH-1:0] redir_aligned;

    assign redir_aligned = fq.redirect_pc & ~WIDTH'(3);
    assign inflight      = {1'b0, alloc_cnt} + {1'b0, drop_cnt};

    assign fq.imem_req_valid = active && !fq.redirect_valid && (inflight < DEPTH_C);
    assign fq.imem_req_addr  = fetch_pc;
    assign issue             = fq.imem_req_valid && fq.imem_req_ready;

    assign resp_drop   = fq.imem_resp_valid && (drop_cnt != '0);
    assign fill        = fq.imem_resp_valid && !fq.redirect_valid &&
                         (drop_cnt == '0) && (pend_cnt != '0);
    assign head_filled = filled[head_ptr];

`ifdef FETCHQ_BYPASS_EN
    assign bypass = fill && !head_filled && (fill_ptr == head_ptr);
`else
    assign bypass = 1'b0;
`endif

    assign fq.out_valid = (head_filled || bypass) && !fq.redirect_valid;
    assign pop          = fq.out_valid && fq.out_ready;

    always_comb begin
        fq.out_instr = '0;
        fq.out_pc    = '0;
        if (bypass) begin
            fq.out_instr = fq.imem_resp_data;
            fq.out_pc    = pc_mem[head_ptr];
        end else if (head_filled) begin
            fq.out_instr = instr_mem[head_ptr];
            fq.out_pc    = pc_mem[head_ptr];
        end
    end

    // Every unfilled allocation is still owed a response; a response arriving now settles one of them.
    always_comb begin
        drop_sum   = drop_cnt + pend_cnt;
        drop_redir = drop_sum;
        if (fq.imem_resp_valid && (drop_sum != '0))
            drop_redir = drop_sum - CNT_W'(1);
    end

    // A bypassed-and-popped entry is set then cleared here, so it is never left stored.
    always_comb begin
        filled_nxt = filled;
        if (fill)
            filled_nxt[fill_ptr] = 1'b1;
        if (pop)
            filled_nxt[head_ptr] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= '0;
            filled    <= '0;
            active    <= 1'b0;
        end else if (fq.redirect_valid) begin
            fetch_pc  <= redir_aligned;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= drop_redir;
            filled    <= '0;
            active    <= 1'b1;
        end else begin
            active <= 1'b1;
            if (issue) begin
                alloc_ptr <= alloc_ptr + PTR_W'(1);
                fetch_pc  <= fetch_pc + WIDTH'(4);
            end
            if (fill)
                fill_ptr <= fill_ptr + PTR_W'(1);
            if (resp_drop)
                drop_cnt <= drop_cnt - CNT_W'(1);
            if (pop)
                head_ptr <= head_ptr + PTR_W'(1);
            alloc_cnt <= alloc_cnt + CNT_W'(issue) - CNT_W'(pop);
            pend_cnt  <= pend_cnt + CNT_W'(issue) - CNT_W'(fill);
            filled    <= filled_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (issue)
            pc_mem[alloc_ptr] <= fetch_pc;
        if (fill)
            instr_mem[fill_ptr] <= fq.imem_resp_data;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order imem model returning data = addr ^ 32'hFFFF_FFFF.
module tb_fetch_queue;
    localparam int W = 32;
`ifdef FETCHQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if #(.WIDTH(W)) fq ();

    fetch_queue #(.WIDTH(W), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq)
    );

    int checks  = 0;
    int errors  = 0;
    int lat     = 1;
    int cyc     = 0;
    int acc_cnt = 0;
    int due_q[$];
    logic [31:0] addr_q[$];

    // Memory model: a request accepted at edge c is captured by the DUT at edge c+lat.
    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            due_q.delete();
            addr_q.delete();
        end else if (fq.imem_req_valid && fq.imem_req_ready) begin
            due_q.push_back(cyc + lat - 1);
            addr_q.push_back(fq.imem_req_addr);
            acc_cnt++;
        end
        #1;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            fq.imem_resp_valid = 1'b1;
            fq.imem_resp_data  = addr_q[0] ^ 32'hFFFF_FFFF;
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
        end else begin
            fq.imem_resp_valid = 1'b0;
            fq.imem_resp_data  = '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset(input int l);
        reset                = 1'b0;
        lat                  = l;
        fq.imem_req_ready    = 1'b0;
        fq.out_ready         = 1'b0;
        fq.redirect_valid    = 1'b0;
        fq.redirect_pc       = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        sample();
        while (fq.out_valid !== 1'b1 && n < 20) begin
            sample();
            n++;
        end
        chk(tag, {31'b0, fq.out_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;
        int          acc_base;
        fq.imem_req_ready = 1'b0;
        fq.out_ready      = 1'b0;
        fq.redirect_valid = 1'b0;
        fq.redirect_pc    = '0;
        #1 reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, fq.out_valid}, 32'd0);
        chk("rst_req_valid", {31'b0, fq.imem_req_valid}, 32'd0);
        chk("rst_out_instr", fq.out_instr, 32'd0);
        chk("rst_out_pc", fq.out_pc, 32'd0);
        chk("rst_req_addr", fq.imem_req_addr, 32'd0);

        // Streaming at full rate, latency 1
        do_reset(1);
        fq.imem_req_ready = 1'b1;
        fq.out_ready      = 1'b1;
        step(); sample();
        chk("t1_req_valid", {31'b0, fq.imem_req_valid}, 32'd1);
        chk("t1_req_addr", fq.imem_req_addr, 32'd0);
        chk("t1_no_early_valid", {31'b0, fq.out_valid}, 32'd0);
        step(); sample();
        chk("t1_first_latency", {31'b0, fq.out_valid}, {31'b0, BYP});
        step(); sample();
        exp_pc = BYP ? 32'h4 : 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("t1_stream_valid", {31'b0, fq.out_valid}, 32'd1);
            chk("t1_stream_pc", fq.out_pc, exp_pc);
            chk("t1_stream_instr", fq.out_instr, ~exp_pc);
            exp_pc = exp_pc + 32'd4;
            step(); sample();
        end

        // Decode stalled: queue fills to DEPTH, then drains in order
        do_reset(1);
        acc_base          = acc_cnt;
        fq.imem_req_ready = 1'b1;
        fq.out_ready      = 1'b0;
        repeat (10) step();
        sample();
        chk("t2_issue_count", acc_cnt - acc_base, 32'd4);
        chk("t2_req_blocked", {31'b0, fq.imem_req_valid}, 32'd0);
        chk("t2_head_valid", {31'b0, fq.out_valid}, 32'd1);
        chk("t2_head_pc", fq.out_pc, 32'd0);
        chk("t2_next_addr", fq.imem_req_addr, 32'h10);
        step();
        fq.out_ready = 1'b1;
        sample();
        exp_pc = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_drain_valid", {31'b0, fq.out_valid}, 32'd1);
            chk("t2_drain_pc", fq.out_pc, exp_pc);
            exp_pc = exp_pc + 32'd4;
            step(); sample();
        end

        // Memory not ready: address held
        do_reset(1);
        acc_base          = acc_cnt;
        fq.imem_req_ready = 1'b0;
        fq.out_ready      = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t3_hold_valid", {31'b0, fq.imem_req_valid}, 32'd1);
            chk("t3_hold_addr", fq.imem_req_addr, 32'd0);
            step();
        end
        fq.imem_req_ready = 1'b1;
        step(); sample();
        chk("t3_advance_addr", fq.imem_req_addr, 32'h4);
        chk("t3_accept_count", acc_cnt - acc_base, 32'd1);

        // Redirect with two stale requests in flight, latency 3
        do_reset(3);
        fq.imem_req_ready = 1'b1;
        fq.out_ready      = 1'b1;
        step(); step(); step();
        fq.imem_req_ready = 1'b0;
        fq.redirect_valid = 1'b1;
        fq.redirect_pc    = 32'h0000_0103;
        sample();
        chk("t4_redir_no_req", {31'b0, fq.imem_req_valid}, 32'd0);
        chk("t4_redir_no_out", {31'b0, fq.out_valid}, 32'd0);
        step();
        fq.redirect_valid = 1'b0;
        fq.imem_req_ready = 1'b1;
        sample();
        chk("t4_new_addr", fq.imem_req_addr, 32'h100);
        chk("t4_new_req_valid", {31'b0, fq.imem_req_valid}, 32'd1);
        wait_valid("t4_wait_valid");
        chk("t4_first_pc", fq.out_pc, 32'h100);
        chk("t4_first_instr", fq.out_instr, ~32'h100);
        sample();
        chk("t4_second_pc", fq.out_pc, 32'h104);
        sample();
        chk("t4_third_pc", fq.out_pc, 32'h108);

        // Redirect coinciding with a response and a would-be pop
        do_reset(1);
        fq.imem_req_ready = 1'b1;
        fq.out_ready      = 1'b1;
        step(); step(); step();
        fq.redirect_valid = 1'b1;
        fq.redirect_pc    = 32'h0000_0200;
        sample();
        chk("t5_redir_out_valid", {31'b0, fq.out_valid}, 32'd0);
        chk("t5_redir_req_valid", {31'b0, fq.imem_req_valid}, 32'd0);
        step();
        fq.redirect_valid = 1'b0;
        sample();
        chk("t5_new_addr", fq.imem_req_addr, 32'h200);
        chk("t5_flushed", {31'b0, fq.out_valid}, 32'd0);
        wait_valid("t5_wait_valid");
        chk("t5_first_pc", fq.out_pc, 32'h200);
        chk("t5_first_instr", fq.out_instr, ~32'h200);
        sample();
        chk("t5_second_pc", fq.out_pc, 32'h204);

        // Asynchronous reset mid-burst with three entries filled
        do_reset(1);
        fq.imem_req_ready = 1'b1;
        fq.out_ready      = 1'b0;
        step(); step(); step(); step();
        fq.imem_req_ready = 1'b0;
        step(); sample();
        chk("t6_pre_out_valid", {31'b0, fq.out_valid}, 32'd1);
        chk("t6_pre_req_valid", {31'b0, fq.imem_req_valid}, 32'd1);
        chk("t6_pre_req_addr", fq.imem_req_addr, 32'hC);
        #1 reset = 1'b0;
        #1;
        chk("t6_rst_out_valid", {31'b0, fq.out_valid}, 32'd0);
        chk("t6_rst_req_valid", {31'b0, fq.imem_req_valid}, 32'd0);
        chk("t6_rst_out_pc", fq.out_pc, 32'd0);
        chk("t6_rst_addr", fq.imem_req_addr, 32'd0);
        step(); step();
        reset             = 1'b1;
        fq.imem_req_ready = 1'b1;
        fq.out_ready      = 1'b1;
        step(); sample();
        chk("t6_resume_req", {31'b0, fq.imem_req_valid}, 32'd1);
        chk("t6_resume_addr", fq.imem_req_addr, 32'd0);
        wait_valid("t6_wait_valid");
        chk("t6_first_pc", fq.out_pc, 32'd0);
        sample();
        chk("t6_second_pc", fq.out_pc, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction prefetch queue for the pipeline fetch stage. It owns the fetch PC, issues in-order requests to instruction memory and buffers the returned words with their PCs. It presents {instr, pc} to the IF/ID enable flop through a valid/ready handshake. Decode's enable (~StallD) is the ready input, and out_valid gates the IF/ID load. A redirect (branch/jump/flush from EX) discards all buffered and in-flight fetches and restarts at the new PC.

Parameters:
WIDTH, 32, instruction and address width
DEPTH, 4, queue entries; power of 2, >= 2
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
redirect_valid  input  1  flush queue and restart fetch at redirect_pc
redirect_pc  input  WIDTH  new fetch PC; bits [1:0] ignored (forced 0)
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  WIDTH  fetch address
imem_resp_valid  input  1  in-order response strobe, latency >= 1 cycle
imem_resp_data  input  WIDTH  fetched instruction
out_valid  output  1  head entry holds a returned instruction
out_ready  input  1  decode consumes head (IF/ID enable)
out_instr  output  WIDTH  head instruction
out_pc  output  WIDTH  PC of head instruction

Behaviour:
- Reset (reset=0, async):
  - fetch_pc=RESET_PC; all pointers, alloc_cnt and drop_cnt = 0; all entries unfilled.
  - Outputs: out_valid=0, imem_req_valid=0, out_instr=0, out_pc=0, imem_req_addr=RESET_PC.
- Entry state: pc, instr, filled bit. Pointers: alloc_ptr, fill_ptr, head_ptr, each mod DEPTH.
  - alloc_cnt = entries allocated (filled or not); pending = allocated but unfilled.
- Issue:
  - imem_req_valid = !redirect_valid && (alloc_cnt + drop_cnt < DEPTH).
  - imem_req_addr = fetch_pc. Addr held stable while valid && !ready, except on redirect.
  - On valid&&ready: allocate entry[alloc_ptr] with pc=fetch_pc, filled=0; alloc_ptr++, alloc_cnt++, fetch_pc += 4 (wraps mod 2^WIDTH).
- Response, registered:
  - If drop_cnt>0: discard and decrement drop_cnt.
  - Else: entry[fill_ptr].instr=data, filled=1, fill_ptr++.
  - A response with no pending entry and drop_cnt==0 is ignored.
- Output:
  - out_valid = entry[head_ptr].filled && !redirect_valid; out_instr/out_pc come from the head entry.
  - Pop on out_valid&&out_ready: head_ptr++, alloc_cnt--, filled cleared.
  - out_ready=0 holds the head stable with no loss.
- Latency: request accepted at cycle t, response at t+k, out_valid at t+k+1.
  - Full throughput (1 instr/cycle) when imem accepts every cycle and out_ready=1.
- Redirect (priority over all other events in its cycle):
  - drop_cnt_next = drop_cnt + pending - (imem_resp_valid ? 1 : 0). A response in the redirect cycle is discarded.
  - All entries unfilled; pointers=0; alloc_cnt=0.
  - fetch_pc = {redirect_pc[WIDTH-1:2],2'b00}.
  - No issue and no pop that cycle.
  - Issue restarts the next cycle.
- Simultaneous events:
  - Issue, fill and pop in the same cycle update alloc_cnt by +1-1.
  - Fill to the head entry with a pop that cycle: pop requires filled at the start of the cycle, so the pop does not consume the entry being filled.
- Full: alloc_cnt+drop_cnt==DEPTH suppresses issue.
- Empty/unfilled head: out_valid=0.

Optional Feature:
FETCHQ_BYPASS_EN
- Defined: when the head entry is unfilled and the response fills it (drop_cnt==0, no redirect), out_valid=1 combinationally that cycle, with out_instr=imem_resp_data and out_pc=entry pc. Latency becomes t+k.
  - If popped that cycle, the entry is not stored.
  - If not popped, it is stored normally.
- Undefined: registered path only, latency t+k+1.

Test Plan:
- Reset release, imem ready always with 1-cycle latency returning data=addr^32'hFFFF_FFFF, out_ready=1 -> out_pc sequence 0,4,8,C... one per cycle, first out_valid 2 cycles after the first accept.
- out_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued (0,4,8,C), imem_req_valid then 0; out_pc holds 0. Release -> pops 0,4,8,C in order, no duplicates.
- imem_req_ready=0 for 3 cycles with req_valid=1 -> imem_req_addr held constant; fetch_pc does not advance.
- Two requests in flight (latency 3), redirect_pc=32'h0000_0103 -> next request addr 32'h0000_0100; the two stale responses are dropped; out_pc first = 100.
- Redirect in the same cycle as imem_resp_valid and out_valid&&out_ready -> out_valid=0 that cycle, response dropped, drop_cnt correct; no stale PC emitted afterwards.
- Async reset asserted mid-burst with 3 entries filled -> out_valid and imem_req_valid drop immediately; after release, fetch resumes at RESET_PC.
